// File: rtl/mem_arbiter_pkg.sv
// Shared types for the instruction/data RAM arbiter: RAM handshake states,
// the machine word and the arbiter FSM encoding.
package mem_arbiter_pkg;

   localparam int unsigned WORD_W         = 32;
   localparam int unsigned STARVE_MAX_DEF = 4;

   typedef logic [WORD_W-1:0] word_t;

   // RAM handshake as reported by the memory controller
   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   // Arbiter ownership of the single RAM port
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GNT_I = 2'd1,
      GNT_D = 2'd2
   } arb_state_t;

endpackage : mem_arbiter_pkg

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported RAM between instruction fetch and data
// access. One requester is granted at a time and holds the port until the RAM
// reports ACCESS. Data wins ties, but after STARVE_MAX consecutive data grants
// with a fetch pending the next grant goes to fetch.
//
// Ports
//   CLK, nRST                 clock (rising edge), async active-low reset
//   iREN, iaddr               fetch request and word address
//   iwait, iload              fetch stall (0 only in completing cycle), fetched word
//   dREN, dWEN, daddr, dstore data request (write wins if both), address, write data
//   dwait, dload              data stall (0 only in completing cycle), read data
//   halt                      blocks new fetch grants; data still served
//   ramREN, ramWEN            RAM strobes
//   ramaddr, ramstore         RAM address and write data
//   ramload, ramstate         RAM read data and handshake state
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic      CLK,
   input  logic      nRST,
   input  logic      iREN,
   input  word_t     iaddr,
   output logic      iwait,
   output word_t     iload,
   input  logic      dREN,
   input  logic      dWEN,
   input  word_t     daddr,
   input  word_t     dstore,
   output logic      dwait,
   output word_t     dload,
   input  logic      halt,
   output logic      ramREN,
   output logic      ramWEN,
   output word_t     ramaddr,
   output word_t     ramstore,
   input  word_t     ramload,
   input  ramstate_t ramstate
);

   localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

   arb_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   word_t            addr_q, addr_d;
   word_t            data_q, data_d;
   logic             wen_q, wen_d;
   logic             retry_q, retry_d;

   logic             d_req;
   logic             cnt_ok;

   // State, latched access and starvation counter
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         wen_q   <= 1'b0;
         retry_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         wen_q   <= wen_d;
         retry_q <= retry_d;
      end
   end

   // Grant selection, RAM drive and requester handshake
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      addr_d   = addr_q;
      data_d   = data_q;
      wen_d    = wen_q;
      retry_d  = 1'b0;
      iwait    = 1'b1;
      dwait    = 1'b1;
      iload    = '0;
      dload    = '0;
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;

      d_req  = dREN | dWEN;
      cnt_ok = (cnt_q < CNT_W'(STARVE_MAX));

      unique case (state_q)
         IDLE: begin
            if (d_req && (cnt_ok || !iREN || halt)) begin
               state_d = GNT_D;
               addr_d  = daddr;
               data_d  = dstore;
               wen_d   = dWEN;
               // Only data grants that bypass a live fetch count toward starvation
               if (iREN && !halt) begin
                  if (cnt_ok) begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end else if (!iREN) begin
                  cnt_d = '0;
               end
            end else if (iREN && !halt) begin
               state_d = GNT_I;
               addr_d  = iaddr;
               data_d  = '0;
               wen_d   = 1'b0;
               cnt_d   = '0;
            end else if (!iREN) begin
               cnt_d = '0;
            end
         end

         GNT_I, GNT_D: begin
            ramaddr  = addr_q;
            ramstore = data_q;
            // retry_q marks the one-cycle strobe gap after an ERROR; RAM status is ignored then
            if (!retry_q) begin
               ramREN = !wen_q;
               ramWEN = wen_q;
               if (ramstate == ACCESS) begin
                  state_d = IDLE;
                  if (state_q == GNT_I) begin
                     iwait = 1'b0;
                     iload = ramload;
                  end else begin
                     dwait = 1'b0;
                     dload = wen_q ? '0 : ramload;
                  end
               end else if (ramstate == ERROR) begin
                  retry_d = 1'b1;
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a RAM model with programmable latency and error
// injection, requester models for fetch and data, and a per-cycle checker that
// compares every completion against a memory model and the access the RAM saw.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   logic      CLK = 1'b0;
   logic      nRST;
   logic      iREN, dREN, dWEN, halt;
   word_t     iaddr, daddr, dstore, ramload;
   ramstate_t ramstate;
   logic      iwait, dwait, ramREN, ramWEN;
   word_t     iload, dload, ramaddr, ramstore;

   mem_arbiter #(.STARVE_MAX(4)) dut (
      .CLK(CLK), .nRST(nRST),
      .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .dwait(dwait), .dload(dload), .halt(halt),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramstate(ramstate)
   );

   always #5 CLK = ~CLK;

   localparam word_t JUNK = 32'hBAD0_BAD0;

   typedef struct {
      bit    ren;
      bit    wen;
      word_t addr;
      word_t data;
   } dop_t;

   int    n_tests = 0;
   int    n_fail  = 0;
   int    cyc     = 0;

   // RAM model
   word_t mem [word_t];
   int    lat = 2;
   int    busy = 0;
   bit    err_inject = 1'b0;
   bit    acc_now;
   bit    last_wen;
   word_t last_addr, last_data;

   // Requester models
   int    i_todo = 0;
   dop_t  dq[$];

   // Per-test observations
   string seq, spat;
   bit    rec_pat = 1'b0;
   int    strobe_cyc, d_low, addr_hits, i_cmp_cyc;
   word_t watch_addr, last_iload, last_dload;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk_s(input string name, input string act, input string exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
      end
   endtask

   function automatic word_t mem_rd(input word_t a);
      if (mem.exists(a)) return mem[a];
      return {a[15:0], 16'h5A5A};
   endfunction

   task automatic drive_req();
      iREN = (i_todo > 0);
      if (dq.size() > 0) begin
         dREN   = dq[0].ren;
         dWEN   = dq[0].wen;
         daddr  = dq[0].addr;
         dstore = dq[0].data;
      end else begin
         dREN = 1'b0;
         dWEN = 1'b0;
      end
   endtask

   // One clock: RAM responds at the falling edge, outputs are checked just after
   task automatic cycle();
      dop_t op;
      @(negedge CLK);
      cyc++;
      acc_now = 1'b0;
      if (ramREN || ramWEN) begin
         strobe_cyc++;
         if (ramaddr == watch_addr) addr_hits++;
         busy++;
         ramload = JUNK;
         if (err_inject) begin
            ramstate   = ERROR;
            err_inject = 1'b0;
            busy       = 0;
         end else if (busy >= lat) begin
            ramstate  = ACCESS;
            busy      = 0;
            acc_now   = 1'b1;
            last_addr = ramaddr;
            last_wen  = ramWEN;
            if (ramWEN) begin
               mem[ramaddr] = ramstore;
               last_data    = ramstore;
            end else begin
               ramload   = mem_rd(ramaddr);
               last_data = ramload;
            end
         end else begin
            ramstate = BUSY;
         end
      end else begin
         ramstate = FREE;
         busy     = 0;
         ramload  = JUNK;
      end
      if (rec_pat) spat = {spat, (ramREN || ramWEN) ? "1" : "0"};
      #1;
      chk("strobe_exclusive", 32'(ramREN && ramWEN), 32'd0);
      chk("wait_exclusive", 32'(!iwait && !dwait), 32'd0);
      if (iwait) chk("iload_when_waiting", iload, 32'd0);
      if (dwait) chk("dload_when_waiting", dload, 32'd0);
      if (!dwait) d_low++;
      if (!iwait) begin
         chk("i_completion_owed", 32'(i_todo > 0), 32'd1);
         chk("i_ram_access", 32'(acc_now), 32'd1);
         chk("i_ram_was_read", 32'(last_wen), 32'd0);
         chk("i_ram_addr", last_addr, iaddr);
         chk("iload", iload, mem_rd(iaddr));
         last_iload = iload;
         i_cmp_cyc  = cyc;
         seq = {seq, "I"};
         if (i_todo > 0) begin
            i_todo--;
            iaddr = iaddr + 32'd4;
         end
      end
      if (!dwait) begin
         chk("d_completion_owed", 32'(dq.size() > 0), 32'd1);
         chk("d_ram_access", 32'(acc_now), 32'd1);
         seq = {seq, "D"};
         if (dq.size() > 0) begin
            op = dq.pop_front();
            chk("d_ram_addr", last_addr, op.addr);
            chk("d_ram_is_write", 32'(last_wen), 32'(op.wen));
            if (op.wen) chk("d_ram_store", last_data, op.data);
            else        chk("dload", dload, mem_rd(op.addr));
            last_dload = dload;
         end
      end
      drive_req();
   endtask

   task automatic run_until_idle(input int budget);
      int k = 0;
      while ((i_todo > 0 || dq.size() > 0) && k < budget) begin
         cycle();
         k++;
      end
      chk("completion_timeout", 32'(i_todo > 0 || dq.size() > 0), 32'd0);
   endtask

   task automatic start_test();
      repeat (2) cycle();
      seq        = "";
      spat       = "";
      strobe_cyc = 0;
      d_low      = 0;
      addr_hits  = 0;
      i_cmp_cyc  = -1;
   endtask

   initial begin
      int start;
      nRST = 1'b0;
      iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; halt = 1'b0;
      iaddr = '0; daddr = '0; dstore = '0;
      ramload = '0; ramstate = FREE;
      watch_addr = 32'hFFFF_FFFF;

      // Reset values
      #12;
      chk("rst_ramREN", 32'(ramREN), 32'd0);
      chk("rst_ramWEN", 32'(ramWEN), 32'd0);
      chk("rst_ramaddr", ramaddr, 32'd0);
      chk("rst_ramstore", ramstore, 32'd0);
      chk("rst_iwait", 32'(iwait), 32'd1);
      chk("rst_dwait", 32'(dwait), 32'd1);
      chk("rst_iload", iload, 32'd0);
      chk("rst_dload", dload, 32'd0);
      @(negedge CLK);
      nRST = 1'b1;

      // Lone fetch, RAM latency 2
      start_test();
      lat = 2;
      mem[32'h40] = 32'h8C22_0004;
      iaddr  = 32'h40;
      i_todo = 1;
      drive_req();
      start = cyc;
      run_until_idle(50);
      chk_s("lone_order", seq, "I");
      chk("lone_latency", 32'(i_cmp_cyc - start), 32'd2);
      chk("lone_strobe_cycles", 32'(strobe_cyc), 32'd2);
      chk("lone_iload_value", last_iload, 32'h8C22_0004);

      // Simultaneous fetch and data write: data first
      start_test();
      iaddr  = 32'h80;
      i_todo = 1;
      dq.push_back('{ren: 1'b0, wen: 1'b1, addr: 32'h100, data: 32'hDEAD_BEEF});
      drive_req();
      run_until_idle(50);
      chk_s("simul_order", seq, "DI");
      chk("simul_ram_written", mem_rd(32'h100), 32'hDEAD_BEEF);

      // dREN and dWEN both high is a write; read it back
      start_test();
      dq.push_back('{ren: 1'b1, wen: 1'b1, addr: 32'h104, data: 32'h1234_5678});
      dq.push_back('{ren: 1'b1, wen: 1'b0, addr: 32'h104, data: 32'h0});
      drive_req();
      run_until_idle(50);
      chk_s("write_wins_order", seq, "DD");
      chk("write_wins_readback", last_dload, 32'h1234_5678);

      // Starvation cap: four data grants, then the pending fetch
      start_test();
      lat    = 1;
      iaddr  = 32'h200;
      i_todo = 1;
      for (int k = 0; k < 6; k++)
         dq.push_back('{ren: 1'b1, wen: 1'b0, addr: 32'h300 + 32'(4 * k), data: 32'h0});
      drive_req();
      run_until_idle(100);
      chk_s("starve_order", seq, "DDDDIDD");

      // ERROR once during a data read: one strobe gap, same address reissued
      start_test();
      lat        = 2;
      mem[32'h400] = 32'hCAFE_F00D;
      watch_addr = 32'h400;
      err_inject = 1'b1;
      rec_pat    = 1'b1;
      dq.push_back('{ren: 1'b1, wen: 1'b0, addr: 32'h400, data: 32'h0});
      drive_req();
      run_until_idle(50);
      rec_pat = 1'b0;
      repeat (3) cycle();
      chk_s("error_strobe_pattern", spat, "1011");
      chk("error_same_addr_strobes", 32'(addr_hits), 32'd3);
      chk("error_dwait_low_once", 32'(d_low), 32'd1);
      chk("error_dload_value", last_dload, 32'hCAFE_F00D);
      watch_addr = 32'hFFFF_FFFF;

      // halt rises mid-fetch: fetch completes, then only data is served
      start_test();
      lat    = 3;
      iaddr  = 32'h500;
      i_todo = 2;
      drive_req();
      cycle();
      halt = 1'b1;
      dq.push_back('{ren: 1'b1, wen: 1'b0, addr: 32'h600, data: 32'h0});
      dq.push_back('{ren: 1'b1, wen: 1'b0, addr: 32'h604, data: 32'h0});
      drive_req();
      repeat (30) cycle();
      chk_s("halt_order", seq, "IDD");
      chk("halt_iwait_held", 32'(iwait), 32'd1);
      chk("halt_fetch_pending", 32'(i_todo), 32'd1);
      halt = 1'b0;
      run_until_idle(50);
      chk_s("unhalt_order", seq, "IDDI");

      // Reset during a data write: strobe drops at once, nothing written
      start_test();
      lat = 10;
      dq.push_back('{ren: 1'b0, wen: 1'b1, addr: 32'h700, data: 32'h1111_2222});
      drive_req();
      repeat (2) cycle();
      chk("pre_reset_ramWEN", 32'(ramWEN), 32'd1);
      nRST = 1'b0;
      #1;
      chk("async_rst_ramWEN", 32'(ramWEN), 32'd0);
      chk("async_rst_dwait", 32'(dwait), 32'd1);
      chk("async_rst_ramaddr", ramaddr, 32'd0);
      dq.delete();
      drive_req();
      cycle();
      nRST = 1'b1;
      cycle();
      chk("post_rst_idle_ramREN", 32'(ramREN), 32'd0);
      chk("post_rst_idle_ramWEN", 32'(ramWEN), 32'd0);
      chk("rst_write_dropped", 32'(mem.exists(32'h700)), 32'd0);
      lat = 2;
      dq.push_back('{ren: 1'b1, wen: 1'b0, addr: 32'h100, data: 32'h0});
      drive_req();
      run_until_idle(50);
      chk_s("post_rst_order", seq, "D");
      chk("post_rst_dload", last_dload, 32'hDEAD_BEEF);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule : tb_mem_arbiter
